dice_rf_port_slice: RTL and testbench
=====================================

# dice_rf_port_slice

One CGRA register-file port slice for the DICE CGRA subsystem. It has three parts:
- a per-thread 32-bit register-file bank, indexed by thread ID;
- read and write address converters with bitwise address override;
- a programmable-latency I/O pipe that aligns bank data with the CGRA fabric.

The RF controller instantiates one slice per port (16 by default).

## Interface
- DATA_WIDTH, 32, data word width.
- NUM_TID, 512, bank depth in entries, one entry per thread ID.
- RF_ADDR_WIDTH, $clog2(NUM_TID), address/TID width.
- MAX_IO_PIPE_STAGE, 8, maximum programmable pipe depth per direction.
- LATW (local), $clog2(MAX_IO_PIPE_STAGE+1), latency field width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of both latency pipes.
- rd_en  in  1  bank read enable.
- rd_tid  in  RF_ADDR_WIDTH  read thread ID.
- rd_data  out  DATA_WIDTH  read data toward the CGRA, after the input pipe.
- wr_en  in  1  bank write enable, applied undelayed.
- wr_tid  in  RF_ADDR_WIDTH  write thread ID, applied undelayed.
- wr_data  in  DATA_WIDTH  write data from the CGRA, enters the output pipe.
- rd_addr_override_enable  in  RF_ADDR_WIDTH  per-bit read-address override mask.
- rd_addr_override_address  in  RF_ADDR_WIDTH  read override bit values.
- wr_addr_override_enable  in  RF_ADDR_WIDTH  per-bit write-address override mask.
- wr_addr_override_address  in  RF_ADDR_WIDTH  write override bit values.
- input_latency  in  LATW  extra cycles on the bank-to-CGRA path.
- output_latency  in  LATW  cycles on the CGRA-to-bank data path.

## Operation
**Address conversion (combinational, one converter per direction)**
- rf_addr = (tid & ~override_enable) | (override_address & override_enable).
- Enable bit = 1 forces that address bit to the override value; enable = 0 passes the TID bit through.

**Bank**
- NUM_TID x DATA_WIDTH memory. Contents are not reset and are undefined until written.
- Write: if wr_en, mem[conv_wr_addr] <= pipe_wr_data at the clock edge.
- Read is synchronous: if rd_en, rdata_q <= mem[conv_rd_addr]. When rd_en = 0, rdata_q holds its value.
- Read and write to the same address in the same cycle return the old data (read-before-write).

**Latency pipes**
- Each direction is a tapped shift register of MAX_IO_PIPE_STAGE stages that shifts every cycle.
  - Input pipe: stage 0 samples rdata_q.
  - Output pipe: stage 0 samples wr_data.
- Tap selection, with L the programmed latency:
  - L = 0: combinational pass-through. rd_data = rdata_q; pipe_wr_data = wr_data.
  - 1 ≤ L ≤ MAX: output = stage[L-1].
  - L > MAX: clamped to MAX.
- Changing a latency value re-selects the tap immediately. The pipe contents are not flushed.
- clr = 1: all stages of both pipes go to 0 on the next edge. Bank contents and rdata_q are unaffected.
- Write alignment is the caller's responsibility: wr_en and wr_tid are not delayed. They must be presented in the cycle the delayed data reaches the bank.

**Reset**
- rst asserted clears rdata_q and every pipe stage to 0, so rd_data = 0.
- Bank contents are unaffected by rst.
- Reset asserted mid-operation aborts in-flight pipe data; no writes occur while rst = 1.

## Timing
- Read:
  - rd_en with rd_tid = t at cycle T → rdata_q updated at edge T+1.
  - rd_data shows mem[conv(t)] from cycle T+1+input_latency.
- Write:
  - wr_data presented at cycle T → reaches the bank write port at cycle T+output_latency (same cycle if L = 0).
  - It is committed at the end of that cycle if wr_en = 1 then.
- Read-after-write: a write committed at edge E is visible to a read issued in the cycle after E.
- The slice has no handshake; it accepts one read and one write per cycle every cycle.

## Test plan
- Write/read, zero latency:
  - Write 0xDEADBEEF to tid 5 with both latencies 0.
  - Read tid 5 next cycle → rd_data = 0xDEADBEEF one cycle after rd_en.
- Override:
  - Write tid 3 with wr_addr_override_enable = 0x1F0, wr_addr_override_address = 0x020; the data lands at address 0x023.
  - Read tid 0x023 with no override → rd_data returns the written word.
- Latency sweep:
  - Set input_latency = 3.
  - Read a known word → it appears exactly 4 cycles after rd_en; rd_data = 0 before that.
  - Set output_latency = 8 with wr_en delayed 8 cycles → the correct word is stored.
  - Set latency 9..15 → behaves as 8.
- Same-address collision: read and write address 7 in the same cycle → rd_data shows the old value; the next read shows the new value.
- clr: with data in flight at input_latency = 5, assert clr one cycle → rd_data = 0 for the remaining in-flight cycles; the bank still holds its data.
- Async reset: assert rst mid-pipe, between clock edges → rd_data = 0 immediately; after release, re-reading a previously written tid returns the stored value.

Source files
------------

// File: rtl/dice_rf_port_slice.sv
// dice_rf_port_slice: per-thread RF bank with address override and programmable-latency I/O pipes
module dice_rf_port_slice #(
    parameter  int DATA_WIDTH        = 32,
    parameter  int NUM_TID           = 512,
    parameter  int RF_ADDR_WIDTH     = $clog2(NUM_TID),
    parameter  int MAX_IO_PIPE_STAGE = 8,
    localparam int LATW              = $clog2(MAX_IO_PIPE_STAGE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     rd_en,
    input  logic [RF_ADDR_WIDTH-1:0] rd_tid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     wr_en,
    input  logic [RF_ADDR_WIDTH-1:0] wr_tid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [RF_ADDR_WIDTH-1:0] rd_addr_override_enable,
    input  logic [RF_ADDR_WIDTH-1:0] rd_addr_override_address,
    input  logic [RF_ADDR_WIDTH-1:0] wr_addr_override_enable,
    input  logic [RF_ADDR_WIDTH-1:0] wr_addr_override_address,
    input  logic [LATW-1:0]          input_latency,
    input  logic [LATW-1:0]          output_latency
);
    localparam logic [LATW-1:0] MAX_LAT = LATW'(MAX_IO_PIPE_STAGE);

    logic [DATA_WIDTH-1:0] mem [NUM_TID];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] pipe_wr_data;
    logic [MAX_IO_PIPE_STAGE-1:0][DATA_WIDTH-1:0] in_pipe, out_pipe;
    logic [MAX_IO_PIPE_STAGE:0][DATA_WIDTH-1:0]   in_tap, out_tap;
    logic [RF_ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [LATW-1:0] in_sel, out_sel;

    assign rd_addr = (rd_tid & ~rd_addr_override_enable) | (rd_addr_override_address & rd_addr_override_enable);
    assign wr_addr = (wr_tid & ~wr_addr_override_enable) | (wr_addr_override_address & wr_addr_override_enable);

    // tap 0 is the undelayed source, tap L is pipe stage L-1; latencies above MAX clamp to MAX
    always_comb begin
        in_sel       = input_latency > MAX_LAT ? MAX_LAT : input_latency;
        out_sel      = output_latency > MAX_LAT ? MAX_LAT : output_latency;
        in_tap       = {in_pipe, rdata_q};
        out_tap      = {out_pipe, wr_data};
        rd_data      = in_tap[in_sel];
        pipe_wr_data = out_tap[out_sel];
    end

    // bank write port; contents survive reset but nothing is written while it is held
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_addr] <= pipe_wr_data;
    end

    // synchronous read, read-before-write on address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_addr];
    end

    // free-running shift pipes in both directions, zeroed by reset or clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            in_pipe  <= '0;
            out_pipe <= '0;
        end else begin
            in_pipe[0]  <= rdata_q;
            out_pipe[0] <= wr_data;
            for (int i = 1; i < MAX_IO_PIPE_STAGE; i++) begin
                in_pipe[i]  <= in_pipe[i-1];
                out_pipe[i] <= out_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_dice_rf_port_slice.sv
// tb_dice_rf_port_slice: directed self-checking bench for the RF port slice
module tb_dice_rf_port_slice;
    logic        clk = 1'b0;
    logic        rst, clr, rd_en, wr_en;
    logic [8:0]  rd_tid, wr_tid;
    logic [31:0] rd_data, wr_data;
    logic [8:0]  rd_oe, rd_oa, wr_oe, wr_oa;
    logic [3:0]  input_latency, output_latency;
    int checks = 0;
    int errors = 0;
    logic [31:0] prev, word;

    dice_rf_port_slice dut (
        .clk(clk), .rst(rst), .clr(clr),
        .rd_en(rd_en), .rd_tid(rd_tid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_tid(wr_tid), .wr_data(wr_data),
        .rd_addr_override_enable(rd_oe), .rd_addr_override_address(rd_oa),
        .wr_addr_override_enable(wr_oe), .wr_addr_override_address(wr_oa),
        .input_latency(input_latency), .output_latency(output_latency)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] tid, input logic [31:0] d);
        wr_en = 1'b1; wr_tid = tid; wr_data = d;
        tick();
        wr_en = 1'b0; wr_data = '0;
    endtask

    task automatic rd(input logic [8:0] tid);
        rd_en = 1'b1; rd_tid = tid;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        rd_tid = '0; wr_tid = '0; wr_data = '0;
        rd_oe = '0; rd_oa = '0; wr_oe = '0; wr_oa = '0;
        input_latency = '0; output_latency = '0;
        tick(); tick();
        chk("reset_rd_data", rd_data, 32'h0);
        rst = 1'b0;

        // zero-latency write then read
        wr(9'd5, 32'hDEADBEEF);
        chk("pre_read_zero", rd_data, 32'h0);
        rd(9'd5);
        chk("rw_lat0", rd_data, 32'hDEADBEEF);

        // write address override: tid 3 lands at 0x023
        wr(9'd3, 32'hAAAA0003);
        wr_oe = 9'h1F0; wr_oa = 9'h020;
        wr(9'd3, 32'h12345678);
        wr_oe = '0; wr_oa = '0;
        rd(9'h023);
        chk("wr_override", rd_data, 32'h12345678);
        rd(9'd3);
        chk("override_untouched", rd_data, 32'hAAAA0003);
        rd_oe = 9'h1FF; rd_oa = 9'h005;
        rd(9'h000);
        chk("rd_override", rd_data, 32'hDEADBEEF);
        rd_oe = '0; rd_oa = '0;

        // input latency 3: zeroed pipe, word appears 4 cycles after rd_en
        rst = 1'b1; tick(); rst = 1'b0;
        input_latency = 4'd3;
        rd_en = 1'b1; rd_tid = 9'h023;
        for (int i = 1; i <= 3; i++) begin
            tick();
            rd_en = 1'b0;
            chk($sformatf("in_lat3_c%0d", i), rd_data, 32'h0);
        end
        tick();
        chk("in_lat3_c4", rd_data, 32'h12345678);
        input_latency = 4'd0;

        // output latency 8 with wr_en aligned 8 cycles later
        output_latency = 4'd8;
        wr_data = 32'hCAFEF00D;
        tick();
        wr_data = 32'h0;
        repeat (7) tick();
        wr(9'd9, 32'h0);
        output_latency = 4'd0;
        rd(9'd9);
        chk("out_lat8", rd_data, 32'hCAFEF00D);

        // latencies 9..15 clamp to 8 in both directions
        prev = 32'hCAFEF00D;
        for (int l = 9; l <= 15; l++) begin
            word = 32'h10000000 + 32'(l);
            output_latency = 4'(l); input_latency = 4'(l);
            wr_data = word;
            tick();
            wr_data = 32'h0;
            repeat (7) tick();
            wr(9'd16, 32'h0);
            rd(9'd16);
            repeat (7) tick();
            chk($sformatf("clamp%0d_early", l), rd_data, prev);
            tick();
            chk($sformatf("clamp%0d_data", l), rd_data, word);
            prev = word;
        end
        input_latency = 4'd0; output_latency = 4'd0;

        // same-address collision returns old data
        wr(9'd7, 32'h11111111);
        rd_en = 1'b1; rd_tid = 9'd7;
        wr(9'd7, 32'h22222222);
        rd_en = 1'b0;
        chk("collision_old", rd_data, 32'h11111111);
        rd(9'd7);
        chk("collision_new", rd_data, 32'h22222222);

        // clr flushes in-flight read data at latency 5
        input_latency = 4'd5;
        rd(9'd5);
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_c4", rd_data, 32'h0);
        for (int i = 5; i <= 8; i++) begin
            tick();
            chk($sformatf("clr_c%0d", i), rd_data, 32'h0);
        end
        tick();
        chk("clr_refill", rd_data, 32'hDEADBEEF);
        input_latency = 4'd0;
        rd(9'h023);
        chk("clr_bank_kept", rd_data, 32'h12345678);

        // asynchronous reset mid-pipe
        input_latency = 4'd2;
        rd(9'd9);
        tick();
        #2 rst = 1'b1;
        #1 chk("async_rst_pipe", rd_data, 32'h0);
        input_latency = 4'd0;
        #1 chk("async_rst_rdata", rd_data, 32'h0);
        rst = 1'b0;
        tick();
        rd(9'd9);
        chk("post_rst_read", rd_data, 32'hCAFEF00D);
        rd(9'd5);
        chk("post_rst_read2", rd_data, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
